// File: rtl/align_lanes_pipe_pkg.sv
// Shared definitions for the lane-alignment pipeline.
// Holds the default geometry (lane count, mantissa/exponent/output widths,
// Q-fraction sideband width) and the output sign-mode encodings.
package align_lanes_pipe_pkg;

    localparam int LANES_DEF = 4;
    localparam int PP_W_DEF  = 3;
    localparam int EXP_W_DEF = 6;
    localparam int OUT_W_DEF = 15;
    localparam int QF_W_DEF  = 5;

    // Output number format of every lane
    typedef enum logic {
        MODE_TWOS     = 1'b0,   // two's complement
        MODE_SIGN_MAG = 1'b1    // sign-magnitude
    } out_mode_e;

endpackage

// File: rtl/align_lanes_pipe_align_lane.sv
// Single-lane aligner: right-shifts one partial-product mantissa by
// (max_exp - exp), collects the shifted-out bits into a sticky flag and
// applies the requested sign format. Two register stages; the load enables
// come from the pipeline control in the top.
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_s1_en, i_s2_en    : stage 1 / stage 2 load enables
//   i_pp                : {sign, mantissa}
//   i_exp, i_max_exp    : lane exponent and shared maximum exponent
//   i_mode              : 0 two's complement, 1 sign-magnitude
//   o_lane              : aligned lane (OUT_W bits)
//   o_sticky, o_err     : OR of lost bits, exponent above max_exp
module align_lane
    import align_lanes_pipe_pkg::*;
#(
    parameter int PP_W  = PP_W_DEF,
    parameter int EXP_W = EXP_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_s1_en,
    input  logic             i_s2_en,
    input  logic [PP_W:0]    i_pp,
    input  logic [EXP_W-1:0] i_exp,
    input  logic [EXP_W-1:0] i_max_exp,
    input  logic             i_mode,
    output logic [OUT_W-1:0] o_lane,
    output logic             o_sticky,
    output logic             o_err
);

    localparam int M     = OUT_W - 1;
    // Working vector: mantissa on top, M magnitude positions, then PP_W guard
    // positions that catch bits falling below the magnitude LSB.
    localparam int EXT_W = M + 2 * PP_W;
    localparam int LOW_W = 2 * PP_W;
    localparam logic [EXP_W:0] EXT_LIM = (EXP_W + 1)'(EXT_W);

    // ---------------- stage 1: difference, err, coarse shift by 4*d[hi]
    logic [EXP_W-1:0]   diff;
    logic               err;
    logic [EXP_W-1:0]   coarse_amt;
    logic [EXT_W-1:0]   ext;
    logic [2*EXT_W-1:0] wide;
    logic [EXT_W-1:0]   vec_next;
    logic               sticky_next;

    always_comb begin
        diff        = i_max_exp - i_exp;
        err         = i_exp > i_max_exp;
        coarse_amt  = {diff[EXP_W-1:2], 2'b00};
        ext         = {i_pp[PP_W-1:0], {(EXT_W - PP_W){1'b0}}};
        // Lower half of the double-width vector receives the shifted-out bits
        wide        = {ext, {EXT_W{1'b0}}} >> coarse_amt;
        vec_next    = wide[2*EXT_W-1 -: EXT_W];
        sticky_next = |wide[EXT_W-1:0];
        if (err) begin
            vec_next    = '0;
            sticky_next = 1'b0;
        end else if ({1'b0, coarse_amt} >= EXT_LIM) begin
            // Entire mantissa shifted past the vector
            vec_next    = '0;
            sticky_next = |i_pp[PP_W-1:0];
        end
    end

    logic [EXT_W-1:0] vec_reg;
    logic             sticky_reg;
    logic             err_reg;
    logic [1:0]       fine_reg;
    logic             sign_reg;
    out_mode_e        mode_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vec_reg    <= '0;
            sticky_reg <= 1'b0;
            err_reg    <= 1'b0;
            fine_reg   <= '0;
            sign_reg   <= 1'b0;
            mode_reg   <= MODE_TWOS;
        end else if (i_s1_en) begin
            vec_reg    <= vec_next;
            sticky_reg <= sticky_next;
            err_reg    <= err;
            fine_reg   <= diff[1:0];
            // An out-of-range lane is forced to a plain zero in both modes
            sign_reg   <= i_pp[PP_W] & ~err;
            mode_reg   <= out_mode_e'(i_mode);
        end
    end

    // ---------------- stage 2: fine shift by d[1:0], sticky, sign format
    logic [EXT_W+2:0] fine_vec;
    logic [EXT_W-1:0] vec2;
    logic [M-1:0]     mag;
    logic             sticky2;
    logic [OUT_W-1:0] lane_abs;
    logic [OUT_W-1:0] lane_neg;
    logic [OUT_W-1:0] lane_next;

    always_comb begin
        fine_vec = {vec_reg, 3'b000} >> fine_reg;
        vec2     = fine_vec[EXT_W+2:3];
        mag      = vec2[EXT_W-1 -: M];
        sticky2  = sticky_reg | (|fine_vec[2:0]) | (|vec2[LOW_W-1:0]);
        lane_abs = {1'b0, mag};
        lane_neg = (~lane_abs) + OUT_W'(1);
        if (mode_reg == MODE_SIGN_MAG) begin
            lane_next = {sign_reg, mag};
        end else begin
            // Negating a zero magnitude yields zero, so -0 never appears
            lane_next = sign_reg ? lane_neg : lane_abs;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_lane   <= '0;
            o_sticky <= 1'b0;
            o_err    <= 1'b0;
        end else if (i_s2_en) begin
            o_lane   <= lane_next;
            o_sticky <= sticky2;
            o_err    <= err_reg;
        end
    end

endmodule

// File: rtl/align_lanes_pipe.sv
// Two-stage exponent-alignment pipeline for LANES partial products with a
// valid/ready handshake. Each lane is shifted right by max_exp - exp;
// max_exp and the Q-fraction sideband travel alongside each beat.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_valid / o_ready       : upstream handshake
//   i_denorm_pp, i_exp      : per-lane {sign, mantissa} and exponent
//   i_max_exp, i_Q_frac     : per-beat sideband
//   i_mode                  : 0 two's complement, 1 sign-magnitude
//   o_valid / i_ready       : downstream handshake
//   o_align_pp              : aligned lanes
//   o_sticky, o_err         : per-lane sticky and exponent-range error
//   o_max_exp, o_Q_frac     : sideband of the presented beat
module align_lanes_pipe
    import align_lanes_pipe_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int PP_W  = PP_W_DEF,
    parameter int EXP_W = EXP_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int QF_W  = QF_W_DEF
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [LANES*(PP_W+1)-1:0] i_denorm_pp,
    input  logic [LANES*EXP_W-1:0]    i_exp,
    input  logic [EXP_W-1:0]          i_max_exp,
    input  logic [QF_W-1:0]           i_Q_frac,
    input  logic                      i_mode,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [LANES*OUT_W-1:0]    o_align_pp,
    output logic [LANES-1:0]          o_sticky,
    output logic [LANES-1:0]          o_err,
    output logic [EXP_W-1:0]          o_max_exp,
    output logic [QF_W-1:0]           o_Q_frac
);

    logic             s1_valid_reg;
    logic             s2_valid_reg;
    logic             s1_en;
    logic             s2_en;
    logic [EXP_W-1:0] s1_max_exp_reg;
    logic [QF_W-1:0]  s1_q_frac_reg;

    // Stage 2 loads whenever it is empty or being drained this cycle;
    // stage 1 is free unless both stages are full and the output stalls.
    assign s2_en   = s1_valid_reg && (!s2_valid_reg || i_ready);
    assign o_ready = !s2_valid_reg || i_ready || !s1_valid_reg;
    assign s1_en   = i_valid && o_ready;
    assign o_valid = s2_valid_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            if (s1_en) begin
                s1_valid_reg <= 1'b1;
            end else if (s2_en) begin
                s1_valid_reg <= 1'b0;
            end
            if (s2_en) begin
                s2_valid_reg <= 1'b1;
            end else if (i_ready) begin
                s2_valid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_max_exp_reg <= '0;
            s1_q_frac_reg  <= '0;
            o_max_exp      <= '0;
            o_Q_frac       <= '0;
        end else begin
            if (s1_en) begin
                s1_max_exp_reg <= i_max_exp;
                s1_q_frac_reg  <= i_Q_frac;
            end
            if (s2_en) begin
                o_max_exp <= s1_max_exp_reg;
                o_Q_frac  <= s1_q_frac_reg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            align_lane #(
                .PP_W  (PP_W),
                .EXP_W (EXP_W),
                .OUT_W (OUT_W)
            ) u_lane (
                .i_clk     (i_clk),
                .i_rst_n   (i_rst_n),
                .i_s1_en   (s1_en),
                .i_s2_en   (s2_en),
                .i_pp      (i_denorm_pp[gi*(PP_W+1) +: PP_W+1]),
                .i_exp     (i_exp[gi*EXP_W +: EXP_W]),
                .i_max_exp (i_max_exp),
                .i_mode    (i_mode),
                .o_lane    (o_align_pp[gi*OUT_W +: OUT_W]),
                .o_sticky  (o_sticky[gi]),
                .o_err     (o_err[gi])
            );
        end
    endgenerate

endmodule

// File: doc/align_lanes_pipe.md
ALIGN_LANES_PIPE -- requirements
Module: align_lanes_pipe

Interface
REQ-001 The block SHALL have parameter LANES, 4, number of partial-product lanes aligned in parallel.
REQ-002 The block SHALL have parameter PP_W, 3, unsigned mantissa width of each partial product, leading one included.
REQ-003 The block SHALL have parameter EXP_W, 6, exponent width.
REQ-004 The block SHALL have parameter OUT_W, 15, aligned output width per lane (sign plus OUT_W-1 magnitude bits, M = OUT_W-1).
REQ-005 The block SHALL have parameter QF_W, 5, width of the Q-fraction sideband.
REQ-006 The block SHALL have port i_clk, input, 1, single clock; all state updates on rising edge.
REQ-007 The block SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-008 The block SHALL have ports i_valid (input, 1, upstream beat valid) and o_ready (output, 1, block accepts a beat).
REQ-009 The block SHALL have port i_denorm_pp, input, LANES*(PP_W+1), per lane {sign, mantissa}; lane k at bits [k*(PP_W+1) +: PP_W+1].
REQ-010 The block SHALL have port i_exp, input, LANES*EXP_W, per-lane exponent, same packing.
REQ-011 The block SHALL have ports i_max_exp (input, EXP_W), i_Q_frac (input, QF_W) and i_mode (input, 1; 0 = two's complement, 1 = sign-magnitude output).
REQ-012 The block SHALL have ports o_valid (output, 1) and i_ready (input, 1, downstream accepts).
REQ-013 The block SHALL have port o_align_pp, output, LANES*OUT_W, aligned lanes.
REQ-014 The block SHALL have ports o_sticky (output, LANES, OR of shifted-out bits per lane), o_err (output, LANES, exp > max_exp per lane), o_max_exp (output, EXP_W), o_Q_frac (output, QF_W).

Function
REQ-015 Per lane, d = i_max_exp - i_exp (EXP_W bits); if i_exp > i_max_exp the lane SHALL output zero magnitude, sticky 0, err 1.
REQ-016 Magnitude SHALL be the upper M bits of ({mantissa, M zero bits} >> d) placed with mantissa MSB at bit M-1 when d = 0; sticky SHALL be OR of every mantissa bit falling below bit 0; d >= M+PP_W gives zero magnitude and sticky = (mantissa != 0).
REQ-017 Sign handling: i_mode=0 -> output = sign ? two's complement of {0, mag} in OUT_W bits : {0, mag}; i_mode=1 -> {sign, mag}; zero magnitude with sign=1 in mode 0 SHALL yield 0.
REQ-018 Pipeline SHALL be two registered stages: S1 registers difference/err and first-half shift select (d[EXP_W-1:2] decoded; rest completed in S2), S2 registers final lane outputs; latency from accepted beat to o_valid = 2 cycles.
REQ-019 Handshake: beat accepted when i_valid && o_ready; output transferred when o_valid && i_ready; o_ready = !S2_valid || i_ready || !S1_valid (bubble collapse permitted).
REQ-020 When o_valid && !i_ready all outputs SHALL hold stable until transfer; no beat dropped or duplicated.
REQ-021 i_max_exp, i_Q_frac and i_mode SHALL travel with their beat and appear on o_max_exp/o_Q_frac alongside it.
REQ-022 With i_ready tied 1 the block SHALL sustain one beat per cycle.
REQ-023 Simultaneous accept and transfer in one cycle SHALL advance both stages with no bubble.

Reset
REQ-024 On i_rst_n low, asynchronously: all valid flags, o_align_pp, o_sticky, o_err, o_max_exp, o_Q_frac SHALL be 0; o_ready SHALL be 1 after reset.
REQ-025 Reset mid-operation SHALL discard in-flight beats; first beat after release appears 2 cycles after acceptance.

Structure
REQ-026 Shared package SHALL hold default LANES/PP_W/EXP_W/OUT_W/QF_W and the mode encodings.
REQ-027 One sub-module align_lane (single-lane shift, sticky, sign) SHALL be instantiated LANES times; handshake/pipeline control stays in the top.

Verification (defaults)
REQ-028 pp=4'b0111, exp=max_exp=20, mode 0 -> lane = 15'h3800, sticky 0, err 0, two cycles later.
REQ-029 pp=4'b1111, d=0, mode 0 -> 15'h4800; mode 1 -> 15'h7800.
REQ-030 pp=4'b0111, d=11 -> 15'h0007, sticky 0; d=12 -> 15'h0003, sticky 1; d=20 -> 15'h0000, sticky 1.
REQ-031 exp=30, max_exp=20 -> lane 0, err 1, sticky 0; other lanes unaffected.
REQ-032 Stream 8 beats, i_ready low for 3 cycles mid-stream -> outputs held, all 8 beats delivered in order with matching o_Q_frac/o_max_exp.
REQ-033 Assert i_rst_n low with 2 beats in flight -> o_valid 0 immediately, no stale beat after release.
